// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side FIFO drain with 2-entry skid buffer and valid/ready stream
module fifo_rd_stream #(
    parameter int WIDTH_FIFO = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_r,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [WIDTH_FIFO-1:0] fifo_rdata,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_FIFO-1:0] m_data,
    output logic [CNT_W-1:0]      rd_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    occ_t                  occ;
    logic                  inflight;
    logic [WIDTH_FIFO-1:0] buf0;
    logic [WIDTH_FIFO-1:0] buf1;
    logic                  pop;
    logic [1:0]            occ_n;
    logic [1:0]            committed;

    assign pop       = m_valid && m_ready;
    assign occ_n     = occ;
    assign committed = occ_n + {1'b0, inflight};

    // Only issue a read when the word it returns is guaranteed a free slot.
    assign fifo_ren = !rst && !flush && !fifo_empty
                      && ((committed - {1'b0, pop}) < 2'd2);

    assign m_valid = (occ != ST_EMPTY);
    assign m_data  = buf0;

    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            occ      <= ST_EMPTY;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            rd_cnt   <= '0;
        end else begin
            inflight <= fifo_ren;
            if (pop)
                rd_cnt <= rd_cnt + CNT_W'(1);
            // A word landing on the flush edge is discarded with the buffer.
            if (flush) begin
                occ <= ST_EMPTY;
            end else begin
                case (occ)
                    ST_EMPTY: begin
                        if (inflight) begin
                            buf0 <= fifo_rdata;
                            occ  <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (inflight && pop) begin
                            buf0 <= fifo_rdata;
                        end else if (inflight) begin
                            buf1 <= fifo_rdata;
                            occ  <= ST_TWO;
                        end else if (pop) begin
                            occ <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (pop) begin
                            buf0 <= buf1;
                            occ  <= ST_ONE;
                        end
                    end
                    default: occ <= ST_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk_r) begin
        if (!rst)
            assert (!(occ == ST_TWO && inflight));
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
`timescale 1ns/100ps
module tb_fifo_rd_stream;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk_r = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_ren;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] rd_cnt;

    always #5 clk_r = ~clk_r;

    fifo_rd_stream #(.WIDTH_FIFO(W), .CNT_W(CW)) dut (
        .clk_r      (clk_r),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_cnt     (rd_cnt)
    );

    typedef struct {
        int           n;
        logic [W-1:0] base;
        int           mode;
    } vec_t;

    typedef struct {
        logic r, f, e, rdy, exp_ren;
    } row_t;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  exp_q[$];
    logic          force_empty;
    logic [CW-1:0] cnt_model;
    int            cyc_n = 0;
    logic          ren_s, valid_s;
    logic [W-1:0]  data_s;
    int ren_cnt, out_cnt, first_ren, last_ren, first_out, last_out, first_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic clr_stats();
        ren_cnt = 0; out_cnt = 0;
        first_ren = -1; last_ren = -1;
        first_out = -1; last_out = -1; first_valid = -1;
    endtask

    // One clock: starts and ends on a falling edge; FIFO model returns rdata after the pop edge.
    task automatic cyc();
        logic [W-1:0] w;
        w = '0;
        fifo_empty = force_empty || (fifo_q.size() == 0);
        #1;
        ren_s   = fifo_ren;
        valid_s = m_valid;
        data_s  = m_data;
        chk("ren_while_empty", {31'd0, ren_s && fifo_empty}, 32'd0);
        if (m_valid && m_ready) begin
            chk("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0)
                chk("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            cnt_model++;
            out_cnt++;
            if (first_out < 0) first_out = cyc_n;
            last_out = cyc_n;
        end
        if (m_valid && first_valid < 0) first_valid = cyc_n;
        if (flush) exp_q.delete();
        if (ren_s && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
        end
        if (ren_s) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc_n;
            last_ren = cyc_n;
        end
        @(posedge clk_r);
        #1;
        if (ren_s) fifo_rdata = w;
        cyc_n++;
        @(negedge clk_r);
    endtask

    task automatic drain(input string nm);
        m_ready = 1'b1;
        force_empty = 1'b0;
        for (int c = 0; c < 300 && (fifo_q.size() > 0 || exp_q.size() > 0); c++)
            cyc();
        chk({nm, "_drain_left"}, fifo_q.size() + exp_q.size(), 32'd0);
        repeat (3) cyc();
        chk({nm, "_rd_cnt"}, {28'd0, rd_cnt}, {28'd0, cnt_model});
        chk({nm, "_idle_valid"}, {31'd0, valid_s}, 32'd0);
    endtask

    task automatic run_stream(input vec_t v);
        int stall_rens;
        stall_rens = 0;
        for (int i = 0; i < v.n; i++) fifo_q.push_back(v.base + W'(i));
        clr_stats();
        force_empty = 1'b0;
        for (int c = 0; c < 300 && (fifo_q.size() > 0 || exp_q.size() > 0); c++) begin
            case (v.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c >= 10);
                2:       m_ready = (c % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            cyc();
            if (v.mode == 1 && c < 10 && ren_s) stall_rens++;
            if (v.mode == 1 && c == 9) begin
                chk("stall_head", {24'd0, data_s}, {24'd0, v.base});
                chk("stall_valid", {31'd0, valid_s}, 32'd1);
            end
        end
        chk("drain_left", fifo_q.size() + exp_q.size(), 32'd0);
        m_ready = 1'b1;
        repeat (3) cyc();
        chk("out_count", out_cnt, v.n);
        chk("ren_count", ren_cnt, v.n);
        chk("rd_cnt", {28'd0, rd_cnt}, {28'd0, cnt_model});
        if (v.mode == 0) begin
            chk("latency", first_valid - first_ren, 32'd2);
            chk("ren_burst", last_ren - first_ren + 1, v.n);
            chk("out_burst", last_out - first_out + 1, v.n);
        end
        if (v.mode == 1) begin
            chk("stall_rens", stall_rens, 32'd2);
            chk("release_burst", last_out - first_out + 1, v.n);
        end
    endtask

    vec_t vecs[5];
    row_t rows[6];

    initial begin
        vecs[0] = '{n: 8,  base: 8'h10, mode: 0};
        vecs[1] = '{n: 8,  base: 8'h10, mode: 1};
        vecs[2] = '{n: 8,  base: 8'h20, mode: 2};
        vecs[3] = '{n: 12, base: 8'h40, mode: 3};
        vecs[4] = '{n: 17, base: 8'h80, mode: 0};
        rows[0] = '{r: 1, f: 0, e: 0, rdy: 1, exp_ren: 0};
        rows[1] = '{r: 0, f: 1, e: 0, rdy: 1, exp_ren: 0};
        rows[2] = '{r: 0, f: 0, e: 1, rdy: 1, exp_ren: 0};
        rows[3] = '{r: 0, f: 0, e: 0, rdy: 1, exp_ren: 1};
        rows[4] = '{r: 0, f: 0, e: 0, rdy: 0, exp_ren: 1};
        rows[5] = '{r: 0, f: 1, e: 1, rdy: 0, exp_ren: 0};

        rst = 1'b1; flush = 1'b0; m_ready = 1'b1; fifo_empty = 1'b0;
        force_empty = 1'b0; fifo_rdata = '0; cnt_model = '0;
        clr_stats();
        repeat (2) @(negedge clk_r);
        #1;
        chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_cnt", {28'd0, rd_cnt}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);

        // Combinational fifo_ren with an empty buffer, all inside one low phase.
        for (int i = 0; i < 6; i++) begin
            rst = rows[i].r; flush = rows[i].f; fifo_empty = rows[i].e; m_ready = rows[i].rdy;
            #0.5;
            chk($sformatf("ren_row%0d", i), {31'd0, fifo_ren}, {31'd0, rows[i].exp_ren});
        end
        rst = 1'b0; flush = 1'b0; fifo_empty = 1'b1; m_ready = 1'b1;
        @(negedge clk_r);

        for (int i = 0; i < 5; i++) run_stream(vecs[i]);

        // Flush while a read is in flight: that word is dropped.
        m_ready = 1'b0; force_empty = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + W'(i));
        cyc();
        chk("pre_flush_ren", {31'd0, ren_s}, 32'd1);
        flush = 1'b1;
        cyc();
        chk("flush_ren", {31'd0, ren_s}, 32'd0);
        flush = 1'b0;
        cyc();
        chk("post_flush_valid", {31'd0, valid_s}, 32'd0);
        drain("flush_inflight");

        // Flush with a full buffer and a pop in the flush cycle.
        m_ready = 1'b0; force_empty = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hB0 + W'(i));
        repeat (4) cyc();
        chk("full_head", {24'd0, data_s}, 32'hB0);
        flush = 1'b1; m_ready = 1'b1;
        cyc();
        flush = 1'b0; m_ready = 1'b0;
        cyc();
        chk("flush_pop_valid", {31'd0, valid_s}, 32'd0);
        drain("flush_pop");

        // FIFO reports empty throughout: no read ever issued.
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'hC0 + W'(i));
        force_empty = 1'b1; m_ready = 1'b1;
        clr_stats();
        repeat (20) cyc();
        chk("empty_no_ren", ren_cnt, 32'd0);
        chk("empty_no_valid", first_valid, -32'sd1);
        drain("after_empty");

        // Reset mid-stream clears everything; remaining FIFO words follow in order.
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hD0 + W'(i));
        force_empty = 1'b0; m_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_ren", {31'd0, fifo_ren}, 32'd0);
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_cnt", {28'd0, rd_cnt}, 32'd0);
        exp_q.delete();
        cnt_model = '0;
        @(posedge clk_r);
        @(negedge clk_r);
        rst = 1'b0;
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
